// File: rtl/pipeline_controller_pkg.sv
// Shared definitions for the pipeline controller: register address width and
// the controller state encoding.
package pipeline_controller_pkg;
  localparam int REG_ADDRESS_LEN = 4;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;
endpackage

// File: rtl/pipeline_controller_hazard_detect.sv
// Combinational RAW hazard check for the two ID-stage sources against EXE/MEM
// destinations; with forwarding on, only a load-use in EXE can stall.
module hazard_detect
  import pipeline_controller_pkg::*;
(
  input  logic [REG_ADDRESS_LEN-1:0] src1,
  input  logic [REG_ADDRESS_LEN-1:0] src2,
  input  logic                       two_src,
  input  logic                       ignore_hazard,
  input  logic [REG_ADDRESS_LEN-1:0] exe_dest,
  input  logic [REG_ADDRESS_LEN-1:0] mem_dest,
  input  logic                       exe_wb_en,
  input  logic                       mem_wb_en,
  input  logic                       exe_mem_read,
  input  logic                       forward_en,
  output logic                       data_hazard
);
  localparam int NSRC = 2;

  logic [NSRC-1:0][REG_ADDRESS_LEN-1:0] src;
  logic [NSRC-1:0]                      src_vld;
  logic [NSRC-1:0]                      exe_hit;
  logic [NSRC-1:0]                      mem_hit;
  logic                                 raw_hit;
  logic                                 load_use;

  assign src     = {src2, src1};
  assign src_vld = {two_src, 1'b1};

  for (genvar s = 0; s < NSRC; s++) begin : g_src
    assign exe_hit[s] = src_vld[s] && (src[s] == exe_dest) && exe_wb_en;
    assign mem_hit[s] = src_vld[s] && (src[s] == mem_dest) && mem_wb_en;
  end

  assign raw_hit     = |exe_hit || |mem_hit;
  assign load_use    = exe_mem_read && |exe_hit;
  assign data_hazard = !ignore_hazard && (forward_en ? load_use : raw_hit);
endmodule

// File: rtl/pipeline_controller.sv
// Pipeline stall/flush controller: memory-wait FSM, branch flush, data-hazard
// bubble, plus saturating stall/flush performance counters.
module pipeline_controller
  import pipeline_controller_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [REG_ADDRESS_LEN-1:0] src1,
  input  logic [REG_ADDRESS_LEN-1:0] src2,
  input  logic                       two_src,
  input  logic                       ignore_hazard,
  input  logic [REG_ADDRESS_LEN-1:0] exe_dest,
  input  logic [REG_ADDRESS_LEN-1:0] mem_dest,
  input  logic                       exe_wb_en,
  input  logic                       mem_wb_en,
  input  logic                       exe_mem_read,
  input  logic                       forward_en,
  input  logic                       branch_taken,
  input  logic                       mem_req,
  input  logic                       mem_ready,
  output logic                       hazard,
  output logic                       if_freeze,
  output logic                       id_freeze,
  output logic                       exe_freeze,
  output logic                       mem_freeze,
  output logic                       if_flush,
  output logic                       id_flush,
  output logic [CNT_W-1:0]           stall_cnt,
  output logic [CNT_W-1:0]           flush_cnt,
  output logic                       mem_wait
);
  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             data_hazard;
  logic             any_freeze;

  hazard_detect u_hazard (
    .src1          (src1),
    .src2          (src2),
    .two_src       (two_src),
    .ignore_hazard (ignore_hazard),
    .exe_dest      (exe_dest),
    .mem_dest      (mem_dest),
    .exe_wb_en     (exe_wb_en),
    .mem_wb_en     (mem_wb_en),
    .exe_mem_read  (exe_mem_read),
    .forward_en    (forward_en),
    .data_hazard   (data_hazard)
  );

  // Priority: memory wait > branch flush > data hazard > idle.
  always_comb begin
    state_d    = state_q;
    hazard     = 1'b0;
    if_freeze  = 1'b0;
    id_freeze  = 1'b0;
    exe_freeze = 1'b0;
    mem_freeze = 1'b0;
    if_flush   = 1'b0;
    id_flush   = 1'b0;
    mem_wait   = 1'b0;
    if (rst) begin
      unique case (state_q)
        MEM_WAIT: begin
          mem_wait = 1'b1;
          if (mem_ready) begin
            state_d = RUN;
          end else begin
            if_freeze  = 1'b1;
            id_freeze  = 1'b1;
            exe_freeze = 1'b1;
            mem_freeze = 1'b1;
          end
        end
        default: begin
          if (mem_req && !mem_ready) begin
            state_d    = MEM_WAIT;
            if_freeze  = 1'b1;
            id_freeze  = 1'b1;
            exe_freeze = 1'b1;
            mem_freeze = 1'b1;
          end else if (branch_taken) begin
            if_flush = 1'b1;
            id_flush = 1'b1;
          end else if (data_hazard) begin
            hazard    = 1'b1;
            if_freeze = 1'b1;
          end
        end
      endcase
    end
  end

  assign any_freeze = if_freeze | id_freeze | exe_freeze | mem_freeze;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (any_freeze && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (if_flush && (flush_cnt_q != '1))   flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_pipeline_controller.sv
// Directed + randomized bench for pipeline_controller; two instances (CNT_W 16
// and 4) share stimulus and are checked against a rule-level reference model.
module tb_pipeline_controller;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] src1, src2, exe_dest, mem_dest;
  logic       two_src, ignore_hazard, exe_wb_en, mem_wb_en, exe_mem_read;
  logic       forward_en, branch_taken, mem_req, mem_ready;

  logic        hz_a, iff_a, idf_a, exf_a, mmf_a, ifl_a, idl_a, mw_a;
  logic        hz_b, iff_b, idf_b, exf_b, mmf_b, ifl_b, idl_b, mw_b;
  logic [15:0] stall_a, flush_a;
  logic [3:0]  stall_b, flush_b;

  int total = 0;
  int bad   = 0;

  // reference model state
  bit     m_wait;
  longint m_stall, m_flush;

  always #5 clk = ~clk;

  pipeline_controller #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .src1(src1), .src2(src2), .two_src(two_src),
    .ignore_hazard(ignore_hazard), .exe_dest(exe_dest), .mem_dest(mem_dest),
    .exe_wb_en(exe_wb_en), .mem_wb_en(mem_wb_en), .exe_mem_read(exe_mem_read),
    .forward_en(forward_en), .branch_taken(branch_taken), .mem_req(mem_req),
    .mem_ready(mem_ready), .hazard(hz_a), .if_freeze(iff_a), .id_freeze(idf_a),
    .exe_freeze(exf_a), .mem_freeze(mmf_a), .if_flush(ifl_a), .id_flush(idl_a),
    .stall_cnt(stall_a), .flush_cnt(flush_a), .mem_wait(mw_a)
  );

  pipeline_controller #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .src1(src1), .src2(src2), .two_src(two_src),
    .ignore_hazard(ignore_hazard), .exe_dest(exe_dest), .mem_dest(mem_dest),
    .exe_wb_en(exe_wb_en), .mem_wb_en(mem_wb_en), .exe_mem_read(exe_mem_read),
    .forward_en(forward_en), .branch_taken(branch_taken), .mem_req(mem_req),
    .mem_ready(mem_ready), .hazard(hz_b), .if_freeze(iff_b), .id_freeze(idf_b),
    .exe_freeze(exf_b), .mem_freeze(mmf_b), .if_flush(ifl_b), .id_flush(idl_b),
    .stall_cnt(stall_b), .flush_cnt(flush_b), .mem_wait(mw_b)
  );

  function automatic longint sat(input longint v, input int w);
    longint mx = (longint'(1) << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  function automatic bit uses(input logic [3:0] d);
    return (src1 == d) || (two_src && (src2 == d));
  endfunction

  // Expected {hazard, if_frz, id_frz, exe_frz, mem_frz, if_fl, id_fl, mem_wait}
  function automatic logic [7:0] exp_out();
    bit dh;
    if (!rst) return 8'h00;
    if (forward_en) dh = exe_mem_read && exe_wb_en && uses(exe_dest);
    else            dh = (exe_wb_en && uses(exe_dest)) || (mem_wb_en && uses(mem_dest));
    if (ignore_hazard) dh = 1'b0;
    if (m_wait)                 return mem_ready ? 8'b0000_0001 : 8'b0111_1001;
    if (mem_req && !mem_ready)  return 8'b0111_1000;
    if (branch_taken)           return 8'b0000_0110;
    if (dh)                     return 8'b1100_0000;
    return 8'h00;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [7:0] e = exp_out();
    check({tag, ":out16"}, {24'd0, hz_a, iff_a, idf_a, exf_a, mmf_a, ifl_a, idl_a, mw_a}, {24'd0, e});
    check({tag, ":out4"},  {24'd0, hz_b, iff_b, idf_b, exf_b, mmf_b, ifl_b, idl_b, mw_b}, {24'd0, e});
    check({tag, ":stall16"}, {16'd0, stall_a}, 32'(sat(m_stall, 16)));
    check({tag, ":flush16"}, {16'd0, flush_a}, 32'(sat(m_flush, 16)));
    check({tag, ":stall4"},  {28'd0, stall_b}, 32'(sat(m_stall, 4)));
    check({tag, ":flush4"},  {28'd0, flush_b}, 32'(sat(m_flush, 4)));
  endtask

  // One clock: check before the edge, then advance the model across it.
  task automatic cyc(input string tag);
    logic [7:0] e;
    @(negedge clk);
    check_all(tag);
    e = exp_out();
    @(posedge clk);
    if (!rst) begin
      m_wait = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (|e[6:3]) m_stall++;
      if (e[2])    m_flush++;
      m_wait = m_wait ? !mem_ready : (mem_req && !mem_ready);
    end
    #1;
  endtask

  task automatic neutral();
    src1 = 4'd1; src2 = 4'd2; exe_dest = 4'd7; mem_dest = 4'd8;
    two_src = 0; ignore_hazard = 0; exe_wb_en = 0; mem_wb_en = 0;
    exe_mem_read = 0; forward_en = 0; branch_taken = 0; mem_req = 0; mem_ready = 0;
  endtask

  initial begin
    neutral();
    m_wait = 0; m_stall = 0; m_flush = 0;
    #2 rst = 1'b0;
    #1 check_all("reset");
    @(posedge clk); #1 rst = 1'b1;
    cyc("idle");

    // RAW on src1 vs EXE without forwarding
    src1 = 4'd3; exe_dest = 4'd3; exe_wb_en = 1;
    cyc("raw_exe");
    check("raw_exe_stall", {16'd0, stall_a}, 32'd1);

    // forwarding: only load-use stalls
    forward_en = 1;
    cyc("fwd_no_load");
    exe_mem_read = 1;
    cyc("fwd_load_use");
    // src2 only counts when two_src
    forward_en = 0; exe_mem_read = 0; src1 = 4'd1; exe_wb_en = 0;
    mem_dest = 4'd5; mem_wb_en = 1; src2 = 4'd5;
    cyc("src2_off");
    two_src = 1;
    cyc("src2_mem");
    ignore_hazard = 1;
    cyc("ignore");
    ignore_hazard = 0;

    // branch beats data hazard
    branch_taken = 1;
    cyc("branch");
    check("branch_flush", {16'd0, flush_a}, 32'd1);
    branch_taken = 0;

    // memory wait: three frozen cycles then release
    neutral();
    mem_req = 1; mem_ready = 0;
    cyc("mw1"); cyc("mw2");
    branch_taken = 1;
    cyc("mw3_branch_ignored");
    branch_taken = 0; mem_ready = 1;
    cyc("mw4");
    mem_req = 0; mem_ready = 0;
    cyc("mw5");
    mem_req = 1; mem_ready = 1;
    cyc("zero_wait");
    mem_req = 0;

    // 20 freeze cycles saturate the 4-bit counter
    src1 = 4'd3; exe_dest = 4'd3; exe_wb_en = 1;
    for (int i = 0; i < 20; i++) cyc("sat");
    check("sat4_hold", {28'd0, stall_b}, 32'd15);

    // asynchronous reset in the middle of a memory wait
    neutral();
    mem_req = 1;
    cyc("pre_rst1"); cyc("pre_rst2");
    src1 = 4'd3; exe_dest = 4'd3; exe_wb_en = 1; branch_taken = 1;
    rst = 1'b0; m_wait = 0; m_stall = 0; m_flush = 0;
    #1 check_all("rst_async");
    cyc("rst_low");
    rst = 1'b1;
    neutral();
    cyc("rst_resume");

    for (int i = 0; i < 600; i++) begin
      src1 = 4'($urandom_range(0, 3)); src2 = 4'($urandom_range(0, 3));
      exe_dest = 4'($urandom_range(0, 3)); mem_dest = 4'($urandom_range(0, 3));
      two_src = 1'($urandom); ignore_hazard = ($urandom_range(0, 7) == 0);
      exe_wb_en = 1'($urandom); mem_wb_en = 1'($urandom);
      exe_mem_read = 1'($urandom); forward_en = 1'($urandom);
      branch_taken = ($urandom_range(0, 4) == 0);
      mem_req = ($urandom_range(0, 3) == 0); mem_ready = 1'($urandom);
      cyc("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
